// File: rtl/eq_solver_pkg.sv
// eq_solver_pkg: shared types and constants for eq_solver_seq; CONCAT_OP_EN selects the base-3 operator set
package eq_solver_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_CAT} op_e;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EVAL, S_NEXT, S_DONE} state_e;
`ifdef CONCAT_OP_EN
    localparam op_e OP_LAST = OP_CAT;
`else
    localparam op_e OP_LAST = OP_MUL;
`endif
    localparam logic [63:0] POW10 [20] = '{
        64'd1, 64'd10, 64'd100, 64'd1000, 64'd10000, 64'd100000, 64'd1000000,
        64'd10000000, 64'd100000000, 64'd1000000000, 64'd10000000000,
        64'd100000000000, 64'd1000000000000, 64'd10000000000000,
        64'd100000000000000, 64'd1000000000000000, 64'd10000000000000000,
        64'd100000000000000000, 64'd1000000000000000000, 64'd10000000000000000000
    };
endpackage

// File: rtl/eq_solver_seq_if.sv
// eq_solver_seq_if: operand-beat input channel and result output channel of eq_solver_seq
interface eq_solver_seq_if #(
    parameter int W       = 64,
    parameter int MAX_OPS = 12
);
    logic                 in_valid, in_ready, in_first, in_last;
    logic [W-1:0]         in_data, in_target;
    logic                 res_valid, res_ready, res_solvable, res_error;
    logic [W-1:0]         res_target;
    logic [2*MAX_OPS-1:0] res_combos;

    modport master (
        output in_valid, in_first, in_last, in_data, in_target, res_ready,
        input  in_ready, res_valid, res_solvable, res_error, res_target, res_combos
    );
    modport slave (
        input  in_valid, in_first, in_last, in_data, in_target, res_ready,
        output in_ready, res_valid, res_solvable, res_error, res_target, res_combos
    );
endinterface

// File: rtl/eq_pow10_sel.sv
// eq_pow10_sel: smallest power of ten above x (10 for x=0); 0 when that power does not fit in W bits
module eq_pow10_sel
    import eq_solver_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] p
);
    always_comb begin
        p = '0;
        for (int k = 19; k >= 1; k--)
            if (64'(x) < POW10[k] && (POW10[k] >> W) == 64'd0) p = W'(POW10[k]);
    end
endmodule

// File: rtl/eq_solver_seq.sv
// eq_solver_seq: sequential +,* equation solver (adds || when CONCAT_OP_EN is defined), one operand per cycle
module eq_solver_seq
    import eq_solver_pkg::*;
#(
    parameter int W       = 64,
    parameter int MAX_OPS = 12
) (
    input logic            clk,
    input logic            rst_n,
    eq_solver_seq_if.slave bus
);
    localparam int NW = $clog2(MAX_OPS + 1);
    typedef logic [NW-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);
    localparam logic [2*MAX_OPS-1:0] C1 = (2*MAX_OPS)'(1);

    state_e               state, state_nx;
    logic [W-1:0]         opnd [MAX_OPS];
    op_e                  dig [MAX_OPS-1];
    op_e                  dig_nx [MAX_OPS-1];
    op_e                  op;
    logic [W-1:0]         target, acc, x, res;
    logic [W:0]           sum;
    logic [2*W-1:0]       prod;
    logic [2*MAX_OPS-1:0] combos;
    cnt_t                 n, idx, wa;
    logic                 nz, err, solv, beat, valid, ovf, at_end, hit, wrap, entry;
`ifdef CONCAT_OP_EN
    logic [W-1:0]         pw [MAX_OPS];
    logic [W-1:0]         p_in;
    logic [2*W-1:0]       cprod;
    logic [W:0]           csum;

    eq_pow10_sel #(.W(W)) u_pow10 (.x(bus.in_data), .p(p_in));
`endif

    assign valid            = state == S_DONE;
    assign beat             = bus.in_valid & bus.in_ready;
    assign bus.in_ready     = rst_n & (state == S_IDLE | state == S_LOAD);
    assign bus.res_valid    = valid;
    assign bus.res_solvable = valid & solv;
    assign bus.res_error    = valid & err;
    assign bus.res_target   = valid ? target : '0;
    assign bus.res_combos   = valid ? combos : '0;
    assign wa               = bus.in_first ? '0 : n;
    assign at_end           = idx + ONE == n;
    assign hit              = !ovf & at_end & (res == target);
    assign entry            = state_nx == S_EVAL & (state == S_IDLE | state == S_LOAD);

    // One step of the current combination; any overflow fails it
    always_comb begin
        x    = opnd[idx];
        op   = dig[idx - ONE];
        sum  = {1'b0, acc} + {1'b0, x};
        prod = {{W{1'b0}}, acc} * {{W{1'b0}}, x};
`ifdef CONCAT_OP_EN
        cprod = {{W{1'b0}}, acc} * {{W{1'b0}}, pw[idx]};
        csum  = {1'b0, cprod[W-1:0]} + {1'b0, x};
        res   = op == OP_MUL ? prod[W-1:0] : op == OP_CAT ? csum[W-1:0] : sum[W-1:0];
        ovf   = op == OP_MUL ? |prod[2*W-1:W] :
                op == OP_CAT ? (|cprod[2*W-1:W]) | csum[W] | (~|pw[idx] & |acc) : sum[W];
`else
        res   = op == OP_MUL ? prod[W-1:0] : sum[W-1:0];
        ovf   = op == OP_MUL ? |prod[2*W-1:W] : sum[W];
`endif
    end

    always_comb begin
        wrap = 1'b1;
        for (int i = 0; i < MAX_OPS - 1; i++) begin
            dig_nx[i] = dig[i];
            if (wrap && i < int'(n) - 1) begin
                wrap      = dig[i] == OP_LAST;
                dig_nx[i] = wrap ? OP_ADD : op_e'(dig[i] + 2'd1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (beat && bus.in_first) state_nx = bus.in_last ? S_EVAL : S_LOAD;
            S_LOAD:  if (beat && bus.in_last) state_nx = S_EVAL;
            S_EVAL:  if (n == ONE || hit) state_nx = S_DONE;
                     else if (ovf || at_end || (nz && res > target)) state_nx = S_NEXT;
            S_NEXT:  state_nx = wrap ? S_DONE : S_EVAL;
            S_DONE:  if (bus.res_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) state <= rst_n ? state_nx : S_IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target <= '0;
            acc    <= '0;
            combos <= '0;
            n      <= '0;
            idx    <= '0;
            nz     <= 1'b0;
            err    <= 1'b0;
            solv   <= 1'b0;
            for (int i = 0; i < MAX_OPS - 1; i++) dig[i] <= OP_ADD;
        end else begin
            if (beat) begin
                if (bus.in_first) begin
                    target <= bus.in_target;
                    n      <= ONE;
                    nz     <= |bus.in_data;
                end else if (state == S_IDLE || n == cnt_t'(MAX_OPS)) begin
                    err <= 1'b1;
                end else begin
                    n  <= n + ONE;
                    nz <= nz & (|bus.in_data);
                end
            end
            if (entry) begin
                acc    <= bus.in_first ? bus.in_data : opnd[0];
                idx    <= ONE;
                combos <= C1;
                solv   <= 1'b0;
                for (int i = 0; i < MAX_OPS - 1; i++) dig[i] <= OP_ADD;
            end
            if (state == S_EVAL) begin
                acc  <= res;
                idx  <= idx + ONE;
                solv <= n == ONE ? acc == target : hit;
            end
            if (state == S_NEXT) begin
                acc <= opnd[0];
                idx <= ONE;
                dig <= dig_nx;
                if (!wrap) combos <= combos + C1;
            end
            if (valid && bus.res_ready) err <= 1'b0;
        end
    end

    // Operand store is deliberately not reset
    always_ff @(posedge clk)
        if (beat && (bus.in_first || (state == S_LOAD && n != cnt_t'(MAX_OPS)))) begin
            opnd[wa] <= bus.in_data;
`ifdef CONCAT_OP_EN
            pw[wa] <= p_in;
`endif
        end
endmodule

// File: tb/tb_eq_solver_seq.sv
// tb_eq_solver_seq: directed checks of eq_solver_seq at W=64 and W=16; expectations follow CONCAT_OP_EN
module tb_eq_solver_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    eq_solver_seq_if #(.W(64), .MAX_OPS(12)) b ();
    eq_solver_seq_if #(.W(16), .MAX_OPS(12)) b16 ();
    eq_solver_seq #(.W(64), .MAX_OPS(12)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    eq_solver_seq #(.W(16), .MAX_OPS(12)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    localparam int NB = 10;
    localparam logic [63:0] TG [NB] = '{190, 3267, 83, 156, 12345, 110, 50, 0, 9, 7};
    localparam logic [63:0] OPS [NB][3] = '{'{10, 19, 0}, '{81, 40, 27}, '{17, 5, 0}, '{15, 6, 0},
        '{12, 345, 0}, '{1, 10, 0}, '{5, 0, 0}, '{3, 4, 0}, '{4, 0, 0}, '{7, 0, 0}};
    localparam int CNT [NB] = '{2, 3, 2, 2, 2, 2, 2, 3, 1, 1};
    localparam logic [15:0] TG16 [4] = '{100, 0, 24464, 65535};
    localparam logic [15:0] A16 [4] = '{300, 65535, 300, 65535};
    localparam logic [15:0] B16 [4] = '{300, 1, 300, 1};
    localparam bit SOL16 [4] = '{0, 0, 0, 1};
`ifdef CONCAT_OP_EN
    localparam bit SOL [NB] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 1};
    localparam int CMB [NB] = '{2, 2, 3, 3, 3, 3, 3, 4, 1, 1};
    localparam int CMB16 [4] = '{3, 3, 3, 2};
`else
    localparam bit SOL [NB] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    localparam int CMB [NB] = '{2, 2, 2, 2, 2, 2, 2, 3, 1, 1};
    localparam int CMB16 [4] = '{2, 2, 2, 2};
`endif

    task automatic send(input logic [63:0] tgt, input bit first, output bit ok);
        int t;
        ok = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            t = 0;
            @(negedge clk);
            b.in_valid  = 1'b1;
            b.in_data   = q[i];
            b.in_first  = first && i == 0;
            b.in_last   = i == q.size() - 1;
            b.in_target = tgt;
            while (!b.in_ready && t < 50) begin @(negedge clk); t++; end
            if (!b.in_ready) ok = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        b.in_valid = 1'b0;
    endtask

    task automatic get_res(output bit ok, output logic sol, output logic [23:0] cmb,
                           output logic er, output logic [63:0] tg, input bit consume);
        int t;
        t = 0;
        while (!b.res_valid && t < 5000) begin @(negedge clk); t++; end
        ok  = b.res_valid;
        sol = b.res_solvable;
        cmb = b.res_combos;
        er  = b.res_error;
        tg  = b.res_target;
        if (consume) begin
            b.res_ready = 1'b1;
            @(negedge clk);
            b.res_ready = 1'b0;
        end
    endtask

    task automatic run_eq(input logic [63:0] tgt, output bit ok, output logic sol,
                          output logic [23:0] cmb, output logic er, output logic [63:0] tg);
        bit sok, rok;
        send(tgt, 1'b1, sok);
        get_res(rok, sol, cmb, er, tg, 1'b1);
        ok = sok & rok;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (b.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got %b want 0", b.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks += 5;
        if (b.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", b.in_ready); end
        if (b.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", b.res_valid); end
        if (b.res_solvable !== 1'b0) begin errors++; $display("FAIL reset_solvable got %b want 0", b.res_solvable); end
        if (b.res_combos !== 24'd0) begin errors++; $display("FAIL reset_combos got %0d want 0", b.res_combos); end
        if (b.res_error !== 1'b0 || b.res_target !== 64'd0) begin
            errors++; $display("FAIL reset_err_target got %b/%0d want 0/0", b.res_error, b.res_target);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic sol, er;
        logic [23:0] cmb;
        logic [63:0] tg;
        for (int k = 0; k < NB; k++) begin
            q.delete();
            for (int j = 0; j < CNT[k]; j++) q.push_back(OPS[k][j]);
            run_eq(TG[k], ok, sol, cmb, er, tg);
            checks += 5;
            if (!ok) begin errors++; $display("FAIL basic[%0d] result got none want res_valid", k); end
            if (sol !== SOL[k]) begin errors++; $display("FAIL basic[%0d] solvable got %b want %b", k, sol, SOL[k]); end
            if (cmb !== 24'(CMB[k])) begin errors++; $display("FAIL basic[%0d] combos got %0d want %0d", k, cmb, CMB[k]); end
            if (er !== 1'b0) begin errors++; $display("FAIL basic[%0d] error got %b want 0", k, er); end
            if (tg !== TG[k]) begin errors++; $display("FAIL basic[%0d] target got %0d want %0d", k, tg, TG[k]); end
        end
    endtask

    task automatic test_hold();
        bit ok;
        logic sol, er;
        logic [23:0] cmb;
        logic [63:0] tg;
        q.delete();
        q.push_back(64'd10);
        q.push_back(64'd19);
        send(64'd190, 1'b1, ok);
        get_res(ok, sol, cmb, er, tg, 1'b0);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_result got none want res_valid"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (b.res_valid !== 1'b1 || b.res_solvable !== 1'b1 || b.res_combos !== 24'd2 ||
                b.res_target !== 64'd190 || b.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got v=%b s=%b c=%0d t=%0d rdy=%b want 1 1 2 190 0", i,
                         b.res_valid, b.res_solvable, b.res_combos, b.res_target, b.in_ready);
            end
        end
        b.res_ready = 1'b1;
        @(negedge clk);
        b.res_ready = 1'b0;
        checks++;
        if (b.res_valid !== 1'b0 || b.in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release got v=%b rdy=%b want 0 1", b.res_valid, b.in_ready);
        end
        q.delete();
        q.push_back(64'd81);
        q.push_back(64'd40);
        q.push_back(64'd27);
        run_eq(64'd3267, ok, sol, cmb, er, tg);
        checks++;
        if (!ok || sol !== 1'b1 || cmb !== 24'd2) begin
            errors++; $display("FAIL hold_next got ok=%b s=%b c=%0d want 1 1 2", ok, sol, cmb);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        logic sol, er;
        logic [23:0] cmb;
        logic [63:0] tg;
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(64'd1);
        send(64'd1000, 1'b1, ok);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (b.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready_low got %b want 0", b.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (b.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", b.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b.res_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_no_result got res_valid=1 want 0"); end
        q.delete();
        q.push_back(64'd5);
        run_eq(64'd5, ok, sol, cmb, er, tg);
        checks++;
        if (!ok || sol !== 1'b1 || cmb !== 24'd1 || er !== 1'b0) begin
            errors++; $display("FAIL midrst_next got ok=%b s=%b c=%0d e=%b want 1 1 1 0", ok, sol, cmb, er);
        end
    endtask

    task automatic test_too_many();
        bit ok;
        logic sol, er;
        logic [23:0] cmb;
        logic [63:0] tg;
        q.delete();
        for (int i = 0; i < 12; i++) q.push_back(64'd1);
        q.push_back(64'd100);
        run_eq(64'd12, ok, sol, cmb, er, tg);
        checks++;
        if (!ok || sol !== 1'b1 || cmb !== 24'd1 || er !== 1'b1) begin
            errors++; $display("FAIL too_many got ok=%b s=%b c=%0d e=%b want 1 1 1 1", ok, sol, cmb, er);
        end
        q.delete();
        q.push_back(64'd10);
        q.push_back(64'd19);
        run_eq(64'd190, ok, sol, cmb, er, tg);
        checks++;
        if (!ok || er !== 1'b0) begin errors++; $display("FAIL too_many_clear got ok=%b e=%b want 1 0", ok, er); end
    endtask

    task automatic test_no_first();
        bit ok;
        logic sol, er;
        logic [23:0] cmb;
        logic [63:0] tg;
        q.delete();
        q.push_back(64'd3);
        send(64'd3, 1'b0, ok);
        q.delete();
        q.push_back(64'd5);
        run_eq(64'd5, ok, sol, cmb, er, tg);
        checks++;
        if (!ok || sol !== 1'b1 || cmb !== 24'd1 || er !== 1'b1) begin
            errors++; $display("FAIL no_first got ok=%b s=%b c=%0d e=%b want 1 1 1 1", ok, sol, cmb, er);
        end
    endtask

    task automatic test_w16();
        int t;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) begin
                t = 0;
                @(negedge clk);
                b16.in_valid  = 1'b1;
                b16.in_first  = i == 0;
                b16.in_last   = i == 1;
                b16.in_data   = i == 0 ? A16[k] : B16[k];
                b16.in_target = TG16[k];
                while (!b16.in_ready && t < 50) begin @(negedge clk); t++; end
                @(posedge clk);
            end
            @(negedge clk);
            b16.in_valid = 1'b0;
            t = 0;
            while (!b16.res_valid && t < 200) begin @(negedge clk); t++; end
            checks += 2;
            if (b16.res_valid !== 1'b1 || b16.res_solvable !== SOL16[k]) begin
                errors++; $display("FAIL w16[%0d] valid/solvable got %b/%b want 1/%b", k,
                                   b16.res_valid, b16.res_solvable, SOL16[k]);
            end
            if (b16.res_combos !== 24'(CMB16[k])) begin
                errors++; $display("FAIL w16[%0d] combos got %0d want %0d", k, b16.res_combos, CMB16[k]);
            end
            b16.res_ready = 1'b1;
            @(negedge clk);
            b16.res_ready = 1'b0;
        end
    endtask

    initial begin
        b.in_valid = 1'b0; b.in_first = 1'b0; b.in_last = 1'b0;
        b.in_data = '0; b.in_target = '0; b.res_ready = 1'b0;
        b16.in_valid = 1'b0; b16.in_first = 1'b0; b16.in_last = 1'b0;
        b16.in_data = '0; b16.in_target = '0; b16.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_too_many();
        test_no_first();
        test_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
